// File: rtl/mux16_rr_arbiter_pkg.sv
// Shared constants and state encoding for the 16-way round-robin mux arbiter.
package mux16_rr_arbiter_pkg;

  localparam int N_REQ = 16;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/mux16_rr_arbiter_rr_pick16.sv
// Rotating priority encoder: first set request at or after ptr, wrapping mod 16.
module rr_pick16
  import mux16_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Walk from the farthest offset back to ptr so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin owner sequencing for a shared 16:1 mux path with hold timeout.
module mux16_rr_arbiter
  import mux16_rr_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 255,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] grant,
  output logic             gnt_valid,
  output logic             timeout
);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic             found;
  logic [SEL_W-1:0] pick_idx;
  logic             at_max;
  logic             release_now;

  rr_pick16 u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (found),
    .idx   (pick_idx)
  );

  // While owning, sel is the owner index, so req[sel] is the owner's own request.
  assign at_max      = (cnt == CNT_W'(HOLD_MAX));
  assign release_now = done | ~req[sel] | at_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      cnt       <= '0;
      sel       <= '0;
      grant     <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en && found) begin
            grant     <= N_REQ'(1) << pick_idx;
            sel       <= pick_idx;
            gnt_valid <= 1'b1;
            cnt       <= CNT_W'(1);
            state     <= ST_OWN;
          end
        end
        ST_OWN: begin
          if (release_now) begin
            grant     <= '0;
            gnt_valid <= 1'b0;
            ptr       <= sel + SEL_W'(1);
            // A voluntary release wins over a coincident hold expiry.
            timeout   <= at_max & ~done & req[sel];
            state     <= ST_GAP;
          end else if (!at_max) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed bench for mux16_rr_arbiter with a short hold limit to reach timeouts quickly.
module tb_mux16_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] req;
  logic        done;
  logic [3:0]  sel;
  logic [15:0] grant;
  logic        gnt_valid;
  logic        timeout;

  int checks;
  int failures;
  int busy_cycles;

  mux16_rr_arbiter #(.HOLD_MAX(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .done      (done),
    .sel       (sel),
    .grant     (grant),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for a grant, then verify who received it.
  task automatic wait_grant(input string tag, input logic [3:0] exp_sel, input int budget);
    for (int n = 0; n < budget; n++) begin
      tick();
      if (gnt_valid) break;
    end
    check_val({tag, "_valid"}, 32'(gnt_valid), 32'd1);
    check_val({tag, "_sel"}, 32'(sel), 32'(exp_sel));
    check_val({tag, "_grant"}, 32'(grant), 32'(16'h0001 << exp_sel));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    req      = 16'h0000;
    done     = 1'b0;

    // Reset state
    repeat (3) tick();
    check_val("rst_grant", 32'(grant), 32'h0);
    check_val("rst_valid", 32'(gnt_valid), 32'h0);
    check_val("rst_sel", 32'(sel), 32'h0);
    check_val("rst_timeout", 32'(timeout), 32'h0);
    check_val("rst_ptr", 32'(dut.ptr), 32'h0);
    rst_n = 1'b1;
    en    = 1'b1;
    tick();

    // Single request: granted one edge after it is presented
    req = 16'h0010;
    tick();
    check_val("single_valid", 32'(gnt_valid), 32'd1);
    check_val("single_sel", 32'(sel), 32'd4);
    check_val("single_grant", 32'(grant), 32'h0010);
    tick();
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 16'h0000;
    check_val("single_release", 32'(gnt_valid), 32'd0);
    check_val("single_rel_grant", 32'(grant), 32'h0);
    check_val("single_ptr", 32'(dut.ptr), 32'd5);
    check_val("single_no_to", 32'(timeout), 32'd0);
    tick();
    tick();

    // Round robin across all requesters from ptr=0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req   = 16'hFFFF;
    for (int i = 0; i <= 16; i++) begin
      tick();
      check_val("rr_sel", 32'(sel), 32'(i % 16));
      check_val("rr_grant", 32'(grant), 32'(16'h0001 << (i % 16)));
      done = 1'b1;
      tick();
      done = 1'b0;
      check_val("rr_gap1", 32'(gnt_valid), 32'd0);
      tick();
      check_val("rr_gap2", 32'(gnt_valid), 32'd0);
    end

    // Wrap-around: serve 13, then ptr=14 must skip 13 and wrap to 0
    req = 16'h2000;
    wait_grant("wrap_13", 4'd13, 4);
    done = 1'b1;
    tick();
    done = 1'b0;
    check_val("wrap_ptr14", 32'(dut.ptr), 32'd14);
    req = 16'h2001;
    wait_grant("wrap_0", 4'd0, 4);
    done = 1'b1;
    tick();
    done = 1'b0;
    check_val("wrap_ptr1", 32'(dut.ptr), 32'd1);

    // Hold timeout: owner 3 keeps requesting without done
    req = 16'h0008;
    wait_grant("to_first", 4'd3, 4);
    for (int c = 2; c <= 4; c++) begin
      tick();
      check_val("to_hold", 32'(gnt_valid), 32'd1);
      check_val("to_no_pulse", 32'(timeout), 32'd0);
    end
    tick();
    check_val("to_evict", 32'(gnt_valid), 32'd0);
    check_val("to_pulse", 32'(timeout), 32'd1);
    tick();
    check_val("to_pulse_end", 32'(timeout), 32'd0);
    check_val("to_idle", 32'(gnt_valid), 32'd0);
    tick();
    check_val("to_regrant_valid", 32'(gnt_valid), 32'd1);
    check_val("to_regrant_sel", 32'(sel), 32'd3);
    // done coincides with the counter reaching the limit
    tick();
    tick();
    tick();
    check_val("to_done_hold", 32'(gnt_valid), 32'd1);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 16'h0000;
    check_val("to_done_rel", 32'(gnt_valid), 32'd0);
    check_val("to_done_no_pulse", 32'(timeout), 32'd0);
    check_val("to_done_ptr", 32'(dut.ptr), 32'd4);

    // Withdraw: owner 7 drops its request while 0 and 8 wait
    req = 16'h0181;
    wait_grant("wd_own7", 4'd7, 4);
    req = 16'h0101;
    tick();
    check_val("wd_release", 32'(gnt_valid), 32'd0);
    check_val("wd_no_to", 32'(timeout), 32'd0);
    wait_grant("wd_next8", 4'd8, 4);
    done = 1'b1;
    tick();
    done = 1'b0;

    // Enable gating: no new grant while en=0
    en  = 1'b0;
    req = 16'hFFFF;
    busy_cycles = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (gnt_valid) busy_cycles++;
    end
    check_val("en_gated", 32'(busy_cycles), 32'd0);
    en = 1'b1;

    // Async reset mid-ownership clears outputs before the next edge
    wait_grant("ar_own9", 4'd9, 4);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("ar_grant", 32'(grant), 32'h0);
    check_val("ar_valid", 32'(gnt_valid), 32'd0);
    check_val("ar_sel", 32'(sel), 32'd0);
    check_val("ar_ptr", 32'(dut.ptr), 32'd0);
    tick();
    rst_n = 1'b1;
    wait_grant("ar_after", 4'd0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
